// File: rtl/pipeline_issue_ctrl.sv
// Issue/sequencing controller for the 3-stage I/A/W pipeline: scoreboarded
// RAW/WAW stalls, multi-cycle A-stage hold, A->W advance and W retire.
module pipeline_issue_ctrl #(
  parameter int NREGS     = 32,
  parameter int RIDX_W    = 5,
  parameter int MULTI_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_multi,
  input  logic              flush,
  output logic              a_load,
  output logic              a_adv,
  output logic              w_retire,
  output logic [RIDX_W-1:0] w_rd,
  output logic              busy
);

  localparam int CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    MWAIT = 2'd2
  } a_state_t;

  a_state_t          a_state, a_state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [RIDX_W-1:0] a_rd;
  logic              a_we;
  logic              w_valid;
  logic [RIDX_W-1:0] w_rd_q;
  logic              w_we;
  logic [NREGS-1:0]  pending, pending_n;
  logic              hazard;
  logic              accept;

  // Hazard looks only at the registered scoreboard; r0 is never a dependency.
  always_comb begin
    hazard = ((in_rs1 != '0) && pending[in_rs1]) ||
             ((in_rs2 != '0) && pending[in_rs2]) ||
             (in_we && (in_rd != '0) && pending[in_rd]);
  end

  // A flush suppresses the advance of the op it kills.
  assign a_adv    = !flush && ((a_state == EXEC) ||
                               ((a_state == MWAIT) && (cnt == CNT_W'(1))));
  assign in_ready = !reset && !flush && !hazard && ((a_state == IDLE) || a_adv);
  assign accept   = in_valid && in_ready;
  assign a_load   = accept;
  assign w_retire = w_valid;
  assign w_rd     = w_rd_q;
  assign busy     = (a_state != IDLE) || w_valid || (|pending);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_state_n = a_state;
    cnt_n     = cnt;
    if (flush) begin
      a_state_n = IDLE;
      cnt_n     = '0;
    end else if (accept) begin
      a_state_n = in_multi ? MWAIT : EXEC;
      cnt_n     = in_multi ? CNT_W'(MULTI_LAT - 1) : '0;
    end else if (a_adv) begin
      a_state_n = IDLE;
      cnt_n     = '0;
    end else if (a_state == MWAIT) begin
      cnt_n = cnt - CNT_W'(1);
    end
  end

  // Retire and flush clears precede the accept set; same-index overlap is
  // ruled out by the WAW stall.
  always_comb begin
    pending_n = pending;
    if (w_valid && w_we) pending_n[w_rd_q] = 1'b0;
    if (flush && (a_state != IDLE) && a_we) pending_n[a_rd] = 1'b0;
    if (accept && in_we) pending_n[in_rd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_state <= IDLE;
      cnt     <= '0;
      a_rd    <= '0;
      a_we    <= 1'b0;
      w_valid <= 1'b0;
      w_rd_q  <= '0;
      w_we    <= 1'b0;
      pending <= '0;
    end else begin
      a_state <= a_state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      if (accept) begin
        a_rd <= in_rd;
        a_we <= in_we;
      end
      w_valid <= a_adv;
      if (a_adv) begin
        w_rd_q <= a_rd;
        w_we   <= a_we;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed self-checking bench for pipeline_issue_ctrl: single ops, RAW, multi,
// WAW with r0, flush in MWAIT and asynchronous reset mid-op.
module tb_pipeline_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_we, in_multi, flush;
  logic       a_load, a_adv, w_retire;
  logic [4:0] w_rd;
  logic       busy;

  int checks = 0;
  int errors = 0;

  pipeline_issue_ctrl #(.NREGS(32), .RIDX_W(5), .MULTI_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_we(in_we), .in_multi(in_multi), .flush(flush),
    .a_load(a_load), .a_adv(a_adv), .w_retire(w_retire),
    .w_rd(w_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we, input logic multi,
                     input logic fl);
    @(negedge clk);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_we = we; in_multi = multi; flush = fl;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_we = 1'b0; in_multi = 1'b0; flush = 1'b0;

    // Reset state
    cyc(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    check("rst_in_ready", in_ready, 0);
    check("rst_a_load", a_load, 0);
    check("rst_a_adv", a_adv, 0);
    check("rst_w_retire", w_retire, 0);
    check("rst_w_rd", w_rd, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    // 1. four independent single ops back to back
    cyc(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    check("t1_load1", a_load, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    check("t1_load2", a_load, 1);
    check("t1_adv2", a_adv, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    check("t1_load3", a_load, 1);
    check("t1_ret_c3", w_retire, 1);
    check("t1_rd_c3", w_rd, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    check("t1_load4", a_load, 1);
    check("t1_rd_c4", w_rd, 2);
    idle_cyc();
    check("t1_ret_c5", w_retire, 1);
    check("t1_rd_c5", w_rd, 3);
    idle_cyc();
    check("t1_ret_c6", w_retire, 1);
    check("t1_rd_c6", w_rd, 4);
    check("t1_busy_c6", busy, 1);
    idle_cyc();
    check("t1_ret_c7", w_retire, 0);
    check("t1_busy_c7", busy, 0);

    // 2. RAW on r5: B issues the cycle after A retires
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("t2_loadA", a_load, 1);
    cyc(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    check("t2_stall_c2", in_ready, 0);
    cyc(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    check("t2_ret_c3", w_retire, 1);
    check("t2_rd_c3", w_rd, 5);
    check("t2_stall_c3", in_ready, 0);
    cyc(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    check("t2_ready_c4", in_ready, 1);
    check("t2_loadB", a_load, 1);
    idle_cyc();
    idle_cyc();
    check("t2_retB", w_rd, 6);
    idle_cyc();
    check("t2_busy_end", busy, 0);

    // 3. multi-cycle op on r7, independent op issues in its a_adv cycle
    cyc(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    check("t3_load_multi", a_load, 1);
    cyc(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("t3_ready_c1", in_ready, 0);
    check("t3_adv_c1", a_adv, 0);
    cyc(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("t3_ready_c2", in_ready, 0);
    check("t3_adv_c2", a_adv, 0);
    cyc(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("t3_adv_c3", a_adv, 1);
    check("t3_load_c3", a_load, 1);
    idle_cyc();
    check("t3_ret_c4", w_retire, 1);
    check("t3_rd_c4", w_rd, 7);
    check("t3_adv_c4", a_adv, 1);
    idle_cyc();
    check("t3_rd_c5", w_rd, 8);
    idle_cyc();
    check("t3_busy_end", busy, 0);

    // 4. r0 write sets nothing; WAW on r9 stalls until first retires
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("t4_load_r0", a_load, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("t4_load_r9a", a_load, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("t4_waw_c3", in_ready, 0);
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("t4_ret_r9", w_rd, 9);
    check("t4_waw_c4", in_ready, 0);
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("t4_load_r9b", a_load, 1);
    idle_cyc();
    idle_cyc();
    idle_cyc();
    check("t4_busy_end", busy, 0);

    // 5. flush a multi op on r3 while cnt==2
    cyc(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    check("t5_load_multi", a_load, 1);
    idle_cyc();
    cyc(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1);
    check("t5_flush_ready", in_ready, 0);
    check("t5_flush_load", a_load, 0);
    check("t5_flush_adv", a_adv, 0);
    cyc(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    check("t5_ready_after", in_ready, 1);
    check("t5_adv_after", a_adv, 0);
    check("t5_noret_c3", w_retire, 0);
    idle_cyc();
    check("t5_noret_c4", w_retire, 0);
    check("t5_adv_c4", a_adv, 1);
    idle_cyc();
    check("t5_ret_r11", w_rd, 11);
    idle_cyc();
    check("t5_busy_end", busy, 0);

    // 6. async reset with W valid and a multi op in MWAIT
    cyc(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0);
    check("t6_load_multi", a_load, 1);
    cyc(1'b1, 5'd13, 5'd12, 5'd14, 1'b1, 1'b0, 1'b0);
    check("t6_pre_ret", w_retire, 1);
    check("t6_pre_ready", in_ready, 0);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_retire", w_retire, 0);
    check("t6_rst_wrd", w_rd, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_load", a_load, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_first_ready", in_ready, 1);
    check("t6_first_load", a_load, 1);
    idle_cyc();
    idle_cyc();
    check("t6_ret_r14", w_rd, 14);
    idle_cyc();
    check("t6_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
